// File: rtl/baser_rx_block_lock_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : baser_rx_block_lock_pkg
//  Brief    : Shared BASE-R constants: sync headers and block-lock states.
//  Revision : 1.0
// ============================================================================
package baser_rx_block_lock_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    localparam logic [1:0] ST_TEST_SH   = 2'd0;
    localparam logic [1:0] ST_SLIP_HIGH = 2'd1;
    localparam logic [1:0] ST_SLIP_LOW  = 2'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/baser_rx_block_lock.sv
`default_nettype none
// ============================================================================
//  Module   : baser_rx_block_lock
//  Brief    : 64b/66b receive block-lock state machine with bitslip control.
//  Revision : 1.0
// ============================================================================
module baser_rx_block_lock
    import baser_rx_block_lock_pkg::*;
#(
    parameter int HDR_WIDTH           = 2,
    parameter int SH_CNT_MAX          = 64,
    parameter int SH_INVALID_MAX      = 16,
    parameter int BITSLIP_HIGH_CYCLES = 1,
    parameter int BITSLIP_LOW_CYCLES  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [HDR_WIDTH-1:0] encoded_rx_hdr,
    input  logic                 encoded_rx_hdr_valid,
    output logic                 serdes_rx_bitslip,
    output logic                 rx_block_lock
);

    localparam int CNT_W = $clog2(SH_CNT_MAX) + 1;
    localparam int INV_W = $clog2(SH_INVALID_MAX) + 1;
    localparam int TMR_W = $clog2(max_int(BITSLIP_HIGH_CYCLES, BITSLIP_LOW_CYCLES)) + 1;

    localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(SH_CNT_MAX);
    localparam logic [INV_W-1:0] C_INV_MAX  = INV_W'(SH_INVALID_MAX);
    localparam logic [TMR_W-1:0] C_HIGH_TMR = TMR_W'(BITSLIP_HIGH_CYCLES - 1);
    localparam logic [TMR_W-1:0] C_LOW_TMR  = TMR_W'(BITSLIP_LOW_CYCLES - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_sh_cnt;
    logic [INV_W-1:0] r_sh_invalid_cnt;
    logic [TMR_W-1:0] r_slip_tmr;
    logic             r_bitslip;
    logic             r_lock;

    logic             w_hdr_invalid;
    logic [CNT_W-1:0] w_n;
    logic [INV_W-1:0] w_inv;

    always_comb begin
        w_hdr_invalid = !((encoded_rx_hdr == SYNC_DATA) || (encoded_rx_hdr == SYNC_CTRL));
        w_n           = r_sh_cnt + 1'b1;
        w_inv         = r_sh_invalid_cnt + {{(INV_W-1){1'b0}}, w_hdr_invalid};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= ST_TEST_SH;
            r_sh_cnt         <= '0;
            r_sh_invalid_cnt <= '0;
            r_slip_tmr       <= '0;
            r_bitslip        <= 1'b0;
            r_lock           <= 1'b0;
        end else begin
            case (r_state)
                ST_TEST_SH: begin
                    if (encoded_rx_hdr_valid) begin
                        // Any invalid header while unlocked slips at once; when
                        // locked only the per-window threshold does.
                        if (w_hdr_invalid && ((w_inv == C_INV_MAX) || !r_lock)) begin
                            r_lock           <= 1'b0;
                            r_sh_cnt         <= '0;
                            r_sh_invalid_cnt <= '0;
                            r_bitslip        <= 1'b1;
                            r_slip_tmr       <= C_HIGH_TMR;
                            r_state          <= ST_SLIP_HIGH;
                        end else if (w_n == C_CNT_MAX) begin
                            r_sh_cnt         <= '0;
                            r_sh_invalid_cnt <= '0;
                            if (w_inv == '0) begin
                                r_lock <= 1'b1;
                            end
                        end else begin
                            r_sh_cnt         <= w_n;
                            r_sh_invalid_cnt <= w_inv;
                        end
                    end
                end
                ST_SLIP_HIGH: begin
                    if (r_slip_tmr == '0) begin
                        r_bitslip  <= 1'b0;
                        r_slip_tmr <= C_LOW_TMR;
                        r_state    <= ST_SLIP_LOW;
                    end else begin
                        r_slip_tmr <= r_slip_tmr - 1'b1;
                    end
                end
                ST_SLIP_LOW: begin
                    if (r_slip_tmr == '0) begin
                        r_sh_cnt         <= '0;
                        r_sh_invalid_cnt <= '0;
                        r_state          <= ST_TEST_SH;
                    end else begin
                        r_slip_tmr <= r_slip_tmr - 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_TEST_SH;
                    r_bitslip <= 1'b0;
                    r_lock    <= 1'b0;
                end
            endcase
        end
    end

    assign serdes_rx_bitslip = r_bitslip;
    assign rx_block_lock     = r_lock;

endmodule
`default_nettype wire

// File: tb/tb_baser_rx_block_lock.sv
`default_nettype none
// ============================================================================
//  Module   : tb_baser_rx_block_lock
//  Brief    : Directed self-checking bench for baser_rx_block_lock.
//  Revision : 1.0
// ============================================================================
module tb_baser_rx_block_lock;

    logic       clk;
    logic       rst_n;
    logic [1:0] encoded_rx_hdr;
    logic       encoded_rx_hdr_valid;
    logic       serdes_rx_bitslip;
    logic       rx_block_lock;

    int r_tests;
    int r_fails;

    baser_rx_block_lock u_dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .encoded_rx_hdr       (encoded_rx_hdr),
        .encoded_rx_hdr_valid (encoded_rx_hdr_valid),
        .serdes_rx_bitslip    (serdes_rx_bitslip),
        .rx_block_lock        (rx_block_lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_tests++;
        if (obs !== exp) begin
            r_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input, then look at the registered outputs just after the edge.
    task automatic send(input logic [1:0] hdr, input logic vld, input logic exp_lock,
                        input logic exp_slip, input string tag);
        encoded_rx_hdr       = hdr;
        encoded_rx_hdr_valid = vld;
        @(posedge clk);
        #1;
        check({tag, "_lock"}, {31'd0, rx_block_lock}, {31'd0, exp_lock});
        check({tag, "_slip"}, {31'd0, serdes_rx_bitslip}, {31'd0, exp_slip});
    endtask

    function automatic logic [1:0] good_hdr(input int i);
        return (i % 2 == 0) ? 2'b01 : 2'b10;
    endfunction

    // After a slip request: one SLIP_HIGH edge plus eight SLIP_LOW edges ignore headers.
    task automatic slip_settle(input string tag);
        for (int k = 0; k < 9; k++) send(2'b00, 1'b1, 1'b0, 1'b0, tag);
    endtask

    initial begin
        r_tests              = 0;
        r_fails              = 0;
        rst_n                = 1'b0;
        encoded_rx_hdr       = 2'b00;
        encoded_rx_hdr_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_lock", {31'd0, rx_block_lock}, 32'd0);
        check("reset_slip", {31'd0, serdes_rx_bitslip}, 32'd0);

        // Acquisition: lock appears right after the 64th good header.
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) send(good_hdr(i), 1'b1, (i == 63), 1'b0, "acquire");

        // Locked window with 15 invalid headers keeps lock.
        for (int i = 0; i < 64; i++)
            send((i < 15) ? 2'b00 : good_hdr(i), 1'b1, 1'b1, 1'b0, "inv15");

        // Locked window with one invalid header keeps lock.
        for (int i = 0; i < 64; i++)
            send((i == 0) ? 2'b11 : good_hdr(i), 1'b1, 1'b1, 1'b0, "inv1_locked");

        // Sixteenth invalid header in a window drops lock and slips.
        for (int i = 0; i < 15; i++) send(2'b00, 1'b1, 1'b1, 1'b0, "inv16_pre");
        send(2'b11, 1'b1, 1'b0, 1'b1, "inv16_hit");
        slip_settle("inv16_settle");

        // Unlocked: single invalid header slips immediately.
        send(2'b00, 1'b1, 1'b0, 1'b1, "unlocked_slip");
        slip_settle("unlocked_settle");

        // Unlocked window with one error slips rather than locking.
        for (int i = 0; i < 10; i++) send(good_hdr(i), 1'b1, 1'b0, 1'b0, "inv1_unl_pre");
        send(2'b11, 1'b1, 1'b0, 1'b1, "inv1_unl_hit");
        slip_settle("inv1_unl_settle");

        // Gated counting: invalid headers with valid=0 are not counted.
        for (int i = 0; i < 64; i++) begin
            send(good_hdr(i), 1'b1, (i == 63), 1'b0, "gated_q");
            send(2'b00, 1'b0, (i == 63), 1'b0, "gated_gap");
        end

        // Reset in SLIP_LOW, then reacquire from a clean state.
        for (int i = 0; i < 15; i++) send(2'b00, 1'b1, 1'b1, 1'b0, "rst_pre");
        send(2'b00, 1'b1, 1'b0, 1'b1, "rst_slip");
        for (int i = 0; i < 3; i++) send(good_hdr(i), 1'b1, 1'b0, 1'b0, "rst_slip_low");
        rst_n = 1'b0;
        send(good_hdr(0), 1'b1, 1'b0, 1'b0, "rst_mid_slip");
        send(good_hdr(1), 1'b1, 1'b0, 1'b0, "rst_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) send(good_hdr(i), 1'b1, (i == 63), 1'b0, "reacquire");

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule
`default_nettype wire
